// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries a data and control bundle between two stages under valid/ready,
// with stall, flush and an optional two-entry skid buffer enabled by defining PIPE_SKID_EN.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on an edge where valid & ready are both high; the sender
  // holds valid and payload stable until then, and a presented entry stays stable while stalled.

  // Encoding doubles as the occupancy count; bit 1 is set only in FULL (skid entry held).
`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1
  } state_e;
`endif

  state_e r_state;
  state_e w_state_nxt;

  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic              w_m_valid;
  logic              w_accept;
  logic              w_consume;
  logic              w_m_load_in;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] r_s_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic              w_m_load_s;
  logic              w_s_load;
`endif

  assign w_m_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_consume = w_m_valid & out_ready;

`ifdef PIPE_SKID_EN
  // Taken straight from the state flop so ready never depends on out_ready.
  assign in_ready = ~r_state[1];
`else
  assign in_ready = ~w_m_valid | out_ready;
`endif

  assign out_valid = w_m_valid;
  assign out_data  = r_m_data;
  assign out_ctrl  = r_m_ctrl & {CTRL_W{w_m_valid}};
  assign occupancy = r_state;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_m_load_in = 1'b0;
`ifdef PIPE_SKID_EN
    w_m_load_s  = 1'b0;
    w_s_load    = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_m_load_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            w_m_load_in = 1'b1;
          end else if (w_accept) begin
`ifdef PIPE_SKID_EN
            w_state_nxt = ST_FULL;
            w_s_load    = 1'b1;
`else
            w_state_nxt = ST_ONE;
`endif
          end else if (w_consume) begin
            w_state_nxt = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        // in_ready is low here, so no accept can coincide with the drain.
        ST_FULL: begin
          if (w_consume) begin
            w_state_nxt = ST_ONE;
            w_m_load_s  = 1'b1;
          end
        end
`endif
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_m_data <= '0;
      r_m_ctrl <= '0;
    end else if (w_m_load_in) begin
      r_m_data <= in_data;
      r_m_ctrl <= in_ctrl;
`ifdef PIPE_SKID_EN
    end else if (w_m_load_s) begin
      r_m_data <= r_s_data;
      r_m_ctrl <= r_s_ctrl;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_s_data <= '0;
      r_s_ctrl <= '0;
    end else if (w_s_load) begin
      r_s_data <= in_data;
      r_s_ctrl <= in_ctrl;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, stall, flush, bubble and mid-stream reset.
// Follows PIPE_SKID_EN the same way as the design.
module tb_pipe_stage_reg;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 16;

  logic              clk;
  logic              clrn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    clrn      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 96'hAB, 16'hFFFF);

    // Reset held with an entry offered
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, 16'h0);
    chk("rst_out_data", out_data, 96'h0);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_dbg_state", dbg_state, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // First accept after release appears one cycle later
    clrn = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 96'hA5, 16'h1234);
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    step();
    chk("first_out_valid", out_valid, 1'b1);
    chk("first_out_data", out_data, 96'hA5);
    chk("first_out_ctrl", out_ctrl, 16'h1234);
    chk("first_occupancy", occupancy, 2'd1);
    drive(1'b0, 96'h0, 16'h0);
    out_ready = 1'b1;
    step();
    chk("first_drained", out_valid, 1'b0);
    chk("first_drained_occ", occupancy, 2'd0);

    // Streaming: 8 back-to-back entries
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DATA_W'(i), CTRL_W'(i));
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      step();
      chk("stream_out_valid", out_valid, 1'b1);
      chk("stream_out_data", out_data, 128'(i));
      chk("stream_out_ctrl", out_ctrl, 128'(i));
    end
    drive(1'b0, 96'h0, 16'h0);
    step();
    chk("stream_end_valid", out_valid, 1'b0);
    chk("stream_end_ctrl", out_ctrl, 16'h0);

`ifdef PIPE_SKID_EN
    // Stall with skid: A then B fill M and S
    out_ready = 1'b0;
    drive(1'b1, 96'h11, 16'h0011);
    step();
    chk("skid_a_occ", occupancy, 2'd1);
    chk("skid_a_in_ready", in_ready, 1'b1);
    drive(1'b1, 96'h22, 16'h0022);
    step();
    chk("skid_b_occ", occupancy, 2'd2);
    chk("skid_b_in_ready", in_ready, 1'b0);
    chk("skid_b_out_data", out_data, 96'h11);
    drive(1'b0, 96'h0, 16'h0);
    out_ready = 1'b1;
    #1;
    chk("skid_ready_registered", in_ready, 1'b0);
    chk("skid_drain_a", out_data, 96'h11);
    step();
    chk("skid_drain_b", out_data, 96'h22);
    chk("skid_drain_b_ctrl", out_ctrl, 16'h0022);
    chk("skid_drain_occ", occupancy, 2'd1);
    chk("skid_ready_back", in_ready, 1'b1);
    step();
    chk("skid_empty_valid", out_valid, 1'b0);
    chk("skid_empty_occ", occupancy, 2'd0);

    // Flush with both entries held and C offered
    out_ready = 1'b0;
    drive(1'b1, 96'h44, 16'h0044);
    step();
    drive(1'b1, 96'h55, 16'h0055);
    step();
    chk("flush_pre_occ", occupancy, 2'd2);
    flush = 1'b1;
    drive(1'b1, 96'h33, 16'h0033);
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    step();
`else
    // Stall without skid: ready drops combinationally, B waits
    out_ready = 1'b0;
    drive(1'b1, 96'h11, 16'h0011);
    step();
    chk("stall_a_occ", occupancy, 2'd1);
    chk("stall_a_out_data", out_data, 96'h11);
    chk("stall_in_ready", in_ready, 1'b0);
    drive(1'b1, 96'h22, 16'h0022);
    step();
    chk("stall_hold_data", out_data, 96'h11);
    chk("stall_hold_occ", occupancy, 2'd1);
    out_ready = 1'b1;
    #1;
    chk("stall_ready_comb", in_ready, 1'b1);
    step();
    chk("stall_b_data", out_data, 96'h22);
    chk("stall_b_ctrl", out_ctrl, 16'h0022);
    drive(1'b0, 96'h0, 16'h0);
    step();
    chk("stall_empty_occ", occupancy, 2'd0);

    // Flush with A held and C offered while ready is high
    out_ready = 1'b0;
    drive(1'b1, 96'h44, 16'h0044);
    step();
    chk("flush_pre_occ", occupancy, 2'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 96'h33, 16'h0033);
    #1;
    chk("flush_in_ready", in_ready, 1'b1);
    step();
`endif
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_ctrl", out_ctrl, 16'h0);
    chk("flush_occ", occupancy, 2'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 96'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_c", out_valid, 1'b0);
    end

    // Bubble: control forced to zero in the invalid slot
    out_ready = 1'b1;
    drive(1'b1, 96'h66, 16'h00FF);
    step();
    chk("bubble_pre_valid", out_valid, 1'b1);
    chk("bubble_pre_ctrl", out_ctrl, 16'h00FF);
    drive(1'b0, 96'h0, 16'h0);
    step();
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_ctrl", out_ctrl, 16'h0);

    // Asynchronous reset mid-stream, then accept on the first edge after release
    out_ready = 1'b0;
    drive(1'b1, 96'h77, 16'h0077);
    step();
    chk("mid_pre_valid", out_valid, 1'b1);
    #2;
    clrn = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ctrl", out_ctrl, 16'h0);
    chk("mid_rst_occ", occupancy, 2'd0);
    step();
    clrn = 1'b1;
    drive(1'b1, 96'h88, 16'h0088);
    step();
    chk("mid_rel_valid", out_valid, 1'b1);
    chk("mid_rel_data", out_data, 96'h88);
    chk("mid_rel_ctrl", out_ctrl, 16'h0088);
    drive(1'b0, 96'h0, 16'h0);
    out_ready = 1'b1;
    step();
    chk("mid_rel_drain", occupancy, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
